// File: rtl/readback_arbiter.sv
// Round-robin arbiter framing byte-stream readback sources into the FTDI write FIFO.
// Each grant emits a header {4'hA, index}, up to MAX_BURST payload bytes and a count trailer.
module readback_arbiter #(
  parameter int unsigned NUM_SRC       = 3,
  parameter int unsigned MAX_BURST     = 64,
  parameter int unsigned STALL_TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_SRC-1:0]     src_valid,
  input  logic [8*NUM_SRC-1:0]   src_data,
  input  logic [NUM_SRC-1:0]     src_last,
  output logic [NUM_SRC-1:0]     src_ready,
  input  logic                   fifo_prog_full,
  output logic                   fifo_wr_en,
  output logic [7:0]             fifo_din,
  output logic [NUM_SRC-1:0]     grant,
  output logic                   busy,
  output logic [7:0]             timeout_count
);

  typedef enum logic [1:0] {StIdle, StHeader, StData, StTrailer} state_e;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic [3:0]         idx_q, idx_d;
  logic [3:0]         ptr_q, ptr_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [15:0]        stall_q, stall_d;
  logic [7:0]         tmo_q, tmo_d;

  logic               found_hi, found_lo;
  logic [3:0]         pick_hi, pick_lo, pick;
  logic               sel_valid, sel_last;
  logic [7:0]         sel_data;
  logic               xfer;
  logic [7:0]         cnt_inc;
  logic [15:0]        stall_inc;

  // Round-robin search: lowest requester at or above the pointer, else lowest overall.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    pick_hi  = '0;
    pick_lo  = '0;
    for (int j = NUM_SRC - 1; j >= 0; j--) begin
      if (src_valid[j]) begin
        if (j >= int'(ptr_q)) begin
          found_hi = 1'b1;
          pick_hi  = 4'(j);
        end
        found_lo = 1'b1;
        pick_lo  = 4'(j);
      end
    end
    pick = found_hi ? pick_hi : pick_lo;
  end

  // Mux the granted source with the one-hot grant.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      if (grant_q[j]) begin
        sel_valid = src_valid[j];
        sel_last  = src_last[j];
        sel_data  = src_data[8*j +: 8];
      end
    end
  end

  assign xfer      = (state_q == StData) && sel_valid && !fifo_prog_full;
  assign cnt_inc   = cnt_q + 8'd1;
  assign stall_inc = stall_q + 16'd1;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    idx_d      = idx_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    stall_d    = stall_q;
    tmo_d      = tmo_q;
    src_ready  = '0;
    fifo_wr_en = 1'b0;
    fifo_din   = '0;

    unique case (state_q)
      StIdle: begin
        if (found_lo) begin
          idx_d = pick;
          for (int j = 0; j < NUM_SRC; j++) begin
            grant_d[j] = (4'(j) == pick);
          end
          state_d = StHeader;
        end
      end
      StHeader: begin
        if (!fifo_prog_full) begin
          fifo_wr_en = 1'b1;
          fifo_din   = {4'hA, idx_q};
          state_d    = StData;
        end
      end
      StData: begin
        src_ready = grant_q & {NUM_SRC{~fifo_prog_full}};
        if (xfer) begin
          fifo_wr_en = 1'b1;
          fifo_din   = sel_data;
          cnt_d      = cnt_inc;
          stall_d    = '0;
          if (sel_last || (cnt_inc == 8'(MAX_BURST))) begin
            state_d = StTrailer;
          end
        end else if (!fifo_prog_full && !sel_valid) begin
          stall_d = stall_inc;
          if (stall_inc == 16'(STALL_TIMEOUT)) begin
            state_d = StTrailer;
            tmo_d   = (tmo_q == 8'hFF) ? tmo_q : tmo_q + 8'd1;
          end
        end
      end
      StTrailer: begin
        if (!fifo_prog_full) begin
          fifo_wr_en = 1'b1;
          fifo_din   = cnt_q;
          cnt_d      = '0;
          stall_d    = '0;
          ptr_d      = (idx_q == 4'(NUM_SRC - 1)) ? 4'd0 : idx_q + 4'd1;
          grant_d    = '0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Nothing may reach the FIFO or a source on a reset edge.
    if (rst) begin
      src_ready  = '0;
      fifo_wr_en = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      stall_q <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      tmo_q   <= tmo_d;
    end
  end

  assign grant         = grant_q;
  assign busy          = (state_q != StIdle);
  assign timeout_count = tmo_q;

endmodule

// File: tb/tb_readback_arbiter.sv
// Bench for readback_arbiter: queue-driven sources, FIFO write collector and a
// packet-level round-robin reference model producing the expected byte stream.
module tb_readback_arbiter;
  localparam int NS = 3;
  localparam int MB = 4;
  localparam int ST = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NS-1:0]   src_valid;
  logic [8*NS-1:0] src_data;
  logic [NS-1:0]   src_last;
  logic [NS-1:0]   src_ready;
  logic            fifo_prog_full;
  logic            fifo_wr_en;
  logic [7:0]      fifo_din;
  logic [NS-1:0]   grant;
  logic            busy;
  logic [7:0]      timeout_count;

  always #5 clk = ~clk;

  readback_arbiter #(
    .NUM_SRC      (NS),
    .MAX_BURST    (MB),
    .STALL_TIMEOUT(ST)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .src_valid     (src_valid),
    .src_data      (src_data),
    .src_last      (src_last),
    .src_ready     (src_ready),
    .fifo_prog_full(fifo_prog_full),
    .fifo_wr_en    (fifo_wr_en),
    .fifo_din      (fifo_din),
    .grant         (grant),
    .busy          (busy),
    .timeout_count (timeout_count)
  );

  int checks = 0;
  int errors = 0;

  // Source-side queues (what the sources still have to send).
  logic [7:0] dq[NS][$];
  bit         dl[NS][$];
  // Reference model queues and pointer.
  logic [7:0] mq[NS][$];
  bit         ml[NS][$];
  int         mptr;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         got_cyc[$];
  int         cyc;
  int         viol;
  logic [NS-1:0] vpulse;
  bit         pf_rand;
  bit         pf_force;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  // Source driver and FIFO collector.
  initial begin
    logic [NS-1:0] acc;
    src_valid      = '0;
    src_data       = '0;
    src_last       = '0;
    fifo_prog_full = 1'b0;
    forever begin
      @(negedge clk);
      if (fifo_wr_en) begin
        got_q.push_back(fifo_din);
        got_cyc.push_back(cyc);
      end
      if (((src_ready & ~grant) != '0) || ($countones(src_ready) > 1) ||
          (busy != (grant != '0))) viol++;
      acc = src_valid & src_ready;
      @(posedge clk);
      cyc++;
      #1;
      for (int k = 0; k < NS; k++) begin
        if (acc[k] && dq[k].size() > 0) begin
          void'(dq[k].pop_front());
          void'(dl[k].pop_front());
        end
      end
      fifo_prog_full = pf_rand ? ($urandom_range(0, 3) == 0) : pf_force;
      for (int k = 0; k < NS; k++) begin
        src_valid[k]       = (dq[k].size() > 0) || vpulse[k];
        src_data[8*k +: 8] = (dq[k].size() > 0) ? dq[k][0] : 8'h00;
        src_last[k]        = (dq[k].size() > 0) ? dl[k][0] : 1'b0;
      end
    end
  end

  task automatic drv_byte(input int k, input logic [7:0] b, input bit l);
    dq[k].push_back(b);
    dl[k].push_back(l);
  endtask

  task automatic push_pkt(input int k, input int len);
    logic [7:0] b;
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom_range(0, 255));
      drv_byte(k, b, i == len - 1);
      mq[k].push_back(b);
      ml[k].push_back(i == len - 1);
    end
  endtask

  // Serve all pending model packets round-robin: header, <=MB bytes, count.
  task automatic model_drain();
    int k;
    int n;
    bit done;
    forever begin
      k = -1;
      for (int i = 0; i < NS; i++) begin
        if (k < 0 && mq[(mptr + i) % NS].size() > 0) k = (mptr + i) % NS;
      end
      if (k < 0) break;
      exp_q.push_back(8'hA0 | 8'(k));
      n = 0;
      done = 1'b0;
      while (!done) begin
        exp_q.push_back(mq[k].pop_front());
        done = ml[k].pop_front();
        n++;
        if (n == MB) done = 1'b1;
      end
      exp_q.push_back(8'(n));
      mptr = (k + 1) % NS;
    end
  endtask

  task automatic wait_writes(input int n, input int budget, input string tag);
    int c;
    c = 0;
    while (got_q.size() < n && c < budget) begin
      @(posedge clk);
      #2;
      c++;
    end
    if (got_q.size() < n) check(tag, got_q.size(), n);
  endtask

  task automatic compare_stream(input string tag);
    wait_writes(exp_q.size(), 600, {tag, "_wait"});
    check({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%s[%0d]", tag, i), (i < got_q.size()) ? {24'd0, got_q[i]} : 32'hDEAD,
            {24'd0, exp_q[i]});
    end
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] b[6];
    int gap;
    int mask;
    pf_rand  = 1'b0;
    pf_force = 1'b0;
    vpulse   = '0;
    mptr     = 0;
    cyc      = 0;
    viol     = 0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_wr_en", fifo_wr_en, 0);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", src_ready, 0);
    check("rst_tmo", timeout_count, 0);
    @(posedge clk);
    #2 rst = 1'b0;

    // Single packet from source 1
    drv_byte(1, 8'h11, 1'b0);
    drv_byte(1, 8'h22, 1'b0);
    drv_byte(1, 8'h33, 1'b1);
    exp_q = '{8'hA1, 8'h11, 8'h22, 8'h33, 8'h03};
    wait_writes(5, 100, "t1_wait");
    @(negedge clk);
    check("t1_busy_after_trailer", busy, 0);
    @(posedge clk);
    #2;
    compare_stream("t1");
    mptr = 2;

    // Sources 0 and 2 competing; pointer starts at 2
    push_pkt(0, 9);
    push_pkt(2, 9);
    model_drain();
    compare_stream("t2");

    // Programmable-full stall mid-DATA
    push_pkt(1, 5);
    model_drain();
    wait_writes(3, 100, "t3_wait");
    pf_force = 1'b1;
    @(posedge clk);
    #2;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t3_stall_ready", src_ready, 0);
      check("t3_stall_wr", fifo_wr_en, 0);
    end
    @(posedge clk);
    #2 pf_force = 1'b0;
    compare_stream("t3");

    // Source 2 stops after two bytes: closed by timeout
    b[0] = 8'($urandom_range(0, 255));
    b[1] = 8'($urandom_range(0, 255));
    drv_byte(2, b[0], 1'b0);
    drv_byte(2, b[1], 1'b0);
    exp_q = '{8'hA2, b[0], b[1], 8'h02};
    wait_writes(4, 100, "t4_wait");
    gap = (got_cyc.size() >= 4) ? got_cyc[3] - got_cyc[2] : 0;
    check("t4_gap_in_range", (gap >= ST && gap <= ST + 1), 1);
    compare_stream("t4");
    check("t4_tmo", timeout_count, 1);
    mptr = 0;

    // Source 0 requests then sends nothing; source 1 served next
    vpulse[0] = 1'b1;
    @(posedge clk);
    #2 vpulse[0] = 1'b0;
    push_pkt(1, 3);
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'h00);
    mptr = 1;
    model_drain();
    compare_stream("t5");
    check("t5_tmo", timeout_count, 2);

    // Reset in the middle of a burst
    for (int i = 0; i < 6; i++) begin
      b[i] = 8'($urandom_range(0, 255));
      drv_byte(2, b[i], i == 5);
    end
    wait_writes(4, 100, "t6_wait");
    dq[2].delete();
    dl[2].delete();
    rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("t6_grant", grant, 0);
    check("t6_busy", busy, 0);
    check("t6_tmo", timeout_count, 0);
    repeat (6) @(posedge clk);
    #2;
    exp_q = '{8'hA2, b[0], b[1], b[2]};
    compare_stream("t6");
    mptr = 0;
    push_pkt(2, 3);
    push_pkt(0, 2);
    model_drain();
    compare_stream("t6_restart");

    // Randomized rounds with random programmable-full
    pf_rand = 1'b1;
    for (int r = 0; r < 6; r++) begin
      mask = $urandom_range(1, (1 << NS) - 1);
      for (int k = 0; k < NS; k++) begin
        if (mask[k]) push_pkt(k, $urandom_range(1, 10));
      end
      model_drain();
      compare_stream($sformatf("rnd%0d", r));
    end
    pf_rand = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("final_tmo", timeout_count, 0);
    check("ready_grant_busy_consistency", viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
